// File: rtl/cpu_ctrl.sv
// Multi-cycle control FSM for a five-class MIPS-style datapath.
// It bounds every memory wait and latches into a sticky FAULT state on a timeout or an illegal opcode.
`timescale 1ns/1ps
module cpu_ctrl #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       zf,
    input  logic       mem_ready,
    output logic       pc_wr,
    output logic       pc_branch,
    output logic       ir_wr,
    output logic       mem_read,
    output logic       mem_wrt,
    output logic       reg_wrt,
    output logic       reg_dst,
    output logic       mem_reg,
    output logic       alu_src,
    output logic [1:0] alu_op,
    output logic [2:0] state,
    output logic       fault
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_FAULT  = 3'd7
    } state_e;

    typedef enum logic [2:0] {
        C_R, C_LW, C_SW, C_BEQ, C_ADDI
    } class_e;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    // The last wait cycle that may still be rescued by mem_ready.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_e     state_q, state_d;
    class_e     class_q, class_d;
    logic [7:0] wait_cnt;
    class_e     dec_class;
    logic       dec_legal;
    logic       mem_wait;
    logic       timed_out;

    // NOTE: every signal written in an always_comb block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        dec_class = C_R;
        dec_legal = 1'b1;
        case (opcode)
            OP_R:    dec_class = C_R;
            OP_LW:   dec_class = C_LW;
            OP_SW:   dec_class = C_SW;
            OP_BEQ:  dec_class = C_BEQ;
            OP_ADDI: dec_class = C_ADDI;
            default: dec_legal = 1'b0;
        endcase
    end

    assign mem_wait  = (state_q == S_FETCH) || (state_q == S_MEM);
    assign timed_out = mem_wait && !mem_ready && (wait_cnt >= WAIT_LAST);

    always_comb begin
        state_d = state_q;
        class_d = class_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready)      state_d = S_DECODE;
                else if (timed_out) state_d = S_FAULT;
            end
            S_DECODE: begin
                if (dec_legal) begin
                    class_d = dec_class;
                    state_d = S_EXEC;
                end else begin
                    state_d = S_FAULT;
                end
            end
            S_EXEC: begin
                case (class_q)
                    C_BEQ:       state_d = S_FETCH;
                    C_LW, C_SW:  state_d = S_MEM;
                    default:     state_d = S_WB;
                endcase
            end
            S_MEM: begin
                if (mem_ready)      state_d = (class_q == C_LW) ? S_WB : S_FETCH;
                else if (timed_out) state_d = S_FAULT;
            end
            S_WB:    state_d = S_FETCH;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_FAULT;
        endcase
    end

    // NOTE: sequential state is updated only with non-blocking assignments, so every register samples the values from before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_FETCH;
            class_q  <= C_R;
            wait_cnt <= '0;
        end else begin
            state_q <= state_d;
            class_q <= class_d;
            if (state_d != state_q)
                wait_cnt <= '0;
            else if (mem_wait && !mem_ready)
                wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // NOTE: the outputs are gated by rst_n itself, so they drop the moment reset asserts and do not wait for a clock edge.
    always_comb begin
        pc_wr     = 1'b0;
        pc_branch = 1'b0;
        ir_wr     = 1'b0;
        mem_read  = 1'b0;
        mem_wrt   = 1'b0;
        reg_wrt   = 1'b0;
        reg_dst   = 1'b0;
        mem_reg   = 1'b0;
        alu_src   = 1'b0;
        alu_op    = 2'b00;
        fault     = 1'b0;
        if (rst_n) begin
            case (state_q)
                S_FETCH: begin
                    mem_read = 1'b1;
                    if (mem_ready) begin
                        ir_wr = 1'b1;
                        pc_wr = 1'b1;
                    end
                end
                S_EXEC, S_MEM, S_WB: begin
                    case (class_q)
                        C_R:    begin reg_dst = 1'b1; alu_op = 2'b10; end
                        C_ADDI: alu_src = 1'b1;
                        C_LW:   begin alu_src = 1'b1; mem_reg = 1'b1; end
                        C_SW:   alu_src = 1'b1;
                        C_BEQ:  alu_op = 2'b01;
                        default: ;
                    endcase
                    if (state_q == S_EXEC && class_q == C_BEQ) begin
                        pc_branch = 1'b1;
                        pc_wr     = zf;
                    end
                    if (state_q == S_MEM) begin
                        mem_read = (class_q == C_LW);
                        mem_wrt  = (class_q == C_SW);
                    end
                    if (state_q == S_WB)
                        reg_wrt = 1'b1;
                end
                S_FAULT: fault = 1'b1;
                default: ;
            endcase
        end
    end

    assign state = state_q;

    mem_excl_a: assert property (@(posedge clk) disable iff (!rst_n) !(mem_read && mem_wrt));
    strobe_place_a: assert property (@(posedge clk) disable iff (!rst_n)
        (!ir_wr || state_q == S_FETCH) && (!reg_wrt || state_q == S_WB));

endmodule

// File: doc/cpu_ctrl.md
CPU_CTRL -- requirements
Module: cpu_ctrl

Interface
REQ-001 SHALL provide parameter MEM_TIMEOUT, default 15, meaning the maximum cycles to wait for mem_ready in FETCH or MEM before faulting (legal range 1..255).
REQ-002 SHALL provide port clk  in  1  rising-edge clock for all state.
REQ-003 SHALL provide port rst_n  in  1  reset: asynchronous assert, active-low, synchronous deassert by the integrator.
REQ-004 SHALL provide port opcode  in  6  inst[31:26] from the instruction register.
REQ-005 SHALL provide port zf  in  1  ALU zero flag.
REQ-006 SHALL provide port mem_ready  in  1  memory completes the current read or write this cycle.
REQ-007 SHALL provide ports pc_wr, pc_branch, ir_wr, mem_read, mem_wrt, reg_wrt  out  1 each, as datapath strobes.
REQ-008 SHALL provide ports reg_dst, mem_reg, alu_src  out  1 each, as datapath mux selects.
REQ-009 SHALL provide port alu_op  out  2  ALUDecoder op: 00 add, 01 sub, 10 use funct.
REQ-010 SHALL provide port state  out  3  current state encoding, for debug.
REQ-011 SHALL provide port fault  out  1  sticky fault indicator.

Function
REQ-012 SHALL implement the states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4 and FAULT=7; encodings 5 and 6 SHALL go to FAULT.
REQ-013 SHALL decode the instruction classes as: R=000000, LW=100011, SW=101011, BEQ=000100, ADDI=001000; any other opcode is illegal.
REQ-014 In FETCH, the block SHALL assert mem_read; when mem_ready=1 it SHALL pulse ir_wr=1 and pc_wr=1 (PC+4, pc_branch=0) in that same cycle and then go to DECODE.
REQ-015 In DECODE, the block SHALL register the class from opcode; an illegal opcode SHALL go to FAULT, otherwise the next state SHALL be EXEC.
REQ-016 In EXEC for BEQ, the block SHALL drive alu_op=01 and pc_branch=1, assert pc_wr=zf, then go to FETCH.
REQ-017 In EXEC for R or ADDI, the next state SHALL be WB; for LW or SW, the next state SHALL be MEM.
REQ-018 In MEM, the block SHALL assert mem_read (LW) or mem_wrt (SW) until mem_ready=1; then LW SHALL go to WB and SW SHALL go to FETCH.
REQ-019 In WB, the block SHALL assert reg_wrt for exactly one cycle, then go to FETCH.
REQ-020 Per class, from DECODE+1 until FETCH re-entry, the selects SHALL be: R: reg_dst=1, alu_src=0, alu_op=10; ADDI: reg_dst=0, alu_src=1, alu_op=00; LW: alu_src=1, alu_op=00, mem_reg=1; SW: alu_src=1, alu_op=00; BEQ: alu_src=0, alu_op=01.
REQ-021 In FETCH, DECODE and FAULT, the selects SHALL all be 0.
REQ-022 mem_read and mem_wrt SHALL never be asserted in the same cycle.
REQ-023 ir_wr SHALL never be asserted outside FETCH, and reg_wrt SHALL never be asserted outside WB.
REQ-024 The block SHALL keep an 8-bit wait counter, cleared on every state change, that increments each FETCH/MEM cycle with mem_ready=0.
REQ-025 When the wait counter reaches MEM_TIMEOUT with mem_ready still 0, the next state SHALL be FAULT.
REQ-026 mem_ready arriving in the same cycle the counter reaches MEM_TIMEOUT SHALL be treated as success, not timeout.
REQ-027 FAULT SHALL be absorbing: fault=1 and all strobes 0 until reset.
REQ-028 mem_ready outside FETCH/MEM SHALL be ignored.
REQ-029 With zero wait states, latency SHALL be: BEQ 3 cycles, R/ADDI/SW 4 cycles, LW 5 cycles.

Reset
REQ-030 While rst_n=0, the block SHALL hold state=FETCH, class=R, counter=0 and fault=0, and SHALL force every output, including mem_read, to 0.
REQ-031 Assertion of rst_n mid-transaction, including MEM with mem_wrt high, SHALL drop all strobes immediately without waiting for clk.
REQ-032 After rst_n rises, the first clk edge SHALL begin a FETCH with mem_read=1.

Verification
REQ-033 Bench SHALL drive reset release, opcode=000000, mem_ready=1 always -> states 0,1,2,4,0; reg_wrt high only in the cycle state=4; reg_dst=1, alu_op=10.
REQ-034 Bench SHALL drive LW with mem_ready low for 3 MEM cycles -> mem_read held 4 cycles in MEM; mem_reg=1; WB follows; total latency 8 cycles.
REQ-035 Bench SHALL drive BEQ with zf=1, then BEQ with zf=0 -> EXEC has pc_branch=1 in both; pc_wr=1 only when zf=1; return to FETCH with no reg_wrt.
REQ-036 Bench SHALL drive opcode=111111 -> FAULT after DECODE; fault=1; no strobes for 20 cycles; rst_n pulse returns state to 0.
REQ-037 Bench SHALL run with MEM_TIMEOUT=4 and mem_ready=0 in FETCH -> FAULT after 4 wait cycles; second run with mem_ready=1 on the 4th cycle -> DECODE instead.
REQ-038 Bench SHALL drive rst_n=0 asynchronously mid-MEM during SW -> mem_wrt falls with no clk edge; FETCH resumes after release.
